mul_pipeline: RTL and testbench

- Parametrised multiply pipeline for the core's MUL functional unit. It replaces the chain of combinational per-stage pass-throughs with a registered pipeline of configurable depth.
- Computes a signed DATA_WIDTH x DATA_WIDTH product and raises an overflow exception.
- Carries the ROB, thread and exception metadata, and supports backpressure, bubble collapsing and per-thread flush.
- Sits between decode/issue and the writeback/ROB arbiter.

---
 rtl/mul_pipeline_pkg.sv | 38 +++
 rtl/mul_pipe_reg.sv | 35 +++
 rtl/mul_pipeline.sv | 106 ++++++++++
 tb/tb_mul_pipeline.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipeline_pkg.sv
// Shared types and sizing for the MUL functional-unit pipeline.
// Field widths mirror the core's ROB, PC, register-file and thread sizing.
package mul_pipeline_pkg;

    localparam int THR_W          = 1;
    localparam int ROB_W          = 6;
    localparam int PC_W           = 32;
    localparam int REG_ADDR_W     = 5;
    localparam int DATA_W         = 32;
    localparam int MUL_NUM_STAGES = 5;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } fetch_xcpt_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] cause;
    } decode_xcpt_t;

    typedef struct packed {
        logic overflow;
    } mul_xcpt_t;

    typedef struct packed {
        logic                  valid;
        logic [THR_W-1:0]      thread_id;
        logic [ROB_W-1:0]      instr_id;
        logic [PC_W-1:0]       pc;
        logic [REG_ADDR_W-1:0] dest_reg;
        logic [DATA_W-1:0]     result;
        fetch_xcpt_t           xcpt_fetch;
        decode_xcpt_t          xcpt_decode;
        mul_xcpt_t             xcpt_mul;
    } mul_pipe_entry_t;

endpackage

// File: rtl/mul_pipe_reg.sv
// One MUL pipeline stage register: load from upstream, otherwise hold,
// dropping the valid bit when the held entry's thread is flushed.
module mul_pipe_reg
    import mul_pipeline_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            load_i,
    input  logic            kill_i,
    input  mul_pipe_entry_t d_i,
    output mul_pipe_entry_t q_o
);

    mul_pipe_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (load_i) begin
            entry_d = d_i;
        end else if (kill_i) begin
            entry_d.valid = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/mul_pipeline.sv
// Registered signed multiply pipeline with overflow detection, backpressure,
// bubble collapsing and per-thread flush.
module mul_pipeline
    import mul_pipeline_pkg::*;
#(
    parameter int NUM_STAGES  = MUL_NUM_STAGES,
    parameter int DATA_WIDTH  = DATA_W,
    parameter int NUM_THREADS = 1 << THR_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [THR_W-1:0]      thread_id_in,
    input  logic [ROB_W-1:0]      instr_id_in,
    input  logic [PC_W-1:0]       program_counter_in,
    input  logic [REG_ADDR_W-1:0] dest_reg_in,
    input  logic [DATA_WIDTH-1:0] src1_data_in,
    input  logic [DATA_WIDTH-1:0] src2_data_in,
    input  fetch_xcpt_t           xcpt_fetch_in,
    input  decode_xcpt_t          xcpt_decode_in,
    input  logic [NUM_THREADS-1:0] flush_mask_in,
    output logic                  resp_valid_out,
    input  logic                  resp_ready_in,
    output logic [THR_W-1:0]      thread_id_out,
    output logic [ROB_W-1:0]      instr_id_out,
    output logic [PC_W-1:0]       program_counter_out,
    output logic [REG_ADDR_W-1:0] dest_reg_out,
    output logic [DATA_WIDTH-1:0] data_result_out,
    output fetch_xcpt_t           xcpt_fetch_out,
    output decode_xcpt_t          xcpt_decode_out,
    output mul_xcpt_t             xcpt_mul_out,
    output logic                  busy_out
);

    logic signed [2*DATA_WIDTH-1:0]    prod;
    mul_pipe_entry_t                   entry_in;
    mul_pipe_entry_t [NUM_STAGES-1:0]  stage_q;
    logic [NUM_STAGES-1:0]             vld, adv, kill;

    assign prod = $signed(src1_data_in) * $signed(src2_data_in);

    // An older fetch/decode exception takes priority, so overflow is masked.
    always_comb begin
        entry_in                      = '0;
        entry_in.valid                = req_valid_in && !flush_mask_in[thread_id_in];
        entry_in.thread_id            = thread_id_in;
        entry_in.instr_id             = instr_id_in;
        entry_in.pc                   = program_counter_in;
        entry_in.dest_reg             = dest_reg_in;
        entry_in.result               = prod[DATA_WIDTH-1:0];
        entry_in.xcpt_fetch           = xcpt_fetch_in;
        entry_in.xcpt_decode          = xcpt_decode_in;
        entry_in.xcpt_mul.overflow    = (prod[2*DATA_WIDTH-1:DATA_WIDTH] != {DATA_WIDTH{prod[DATA_WIDTH-1]}})
                                        && !xcpt_fetch_in.valid && !xcpt_decode_in.valid;
    end

    // A stage may advance if it or any stage downstream of it is empty.
    always_comb begin : adv_chain
        logic a;
        a   = resp_ready_in;
        adv = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            a      = a || !vld[i];
            adv[i] = a;
        end
    end

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        mul_pipe_entry_t d;

        assign vld[i]  = stage_q[i].valid;
        assign kill[i] = stage_q[i].valid && flush_mask_in[stage_q[i].thread_id];

        if (i == 0) begin : g_head
            assign d = entry_in;
        end else begin : g_body
            always_comb begin
                d       = stage_q[i-1];
                d.valid = vld[i-1] && !kill[i-1];
            end
        end

        mul_pipe_reg u_reg (
            .clock  (clock),
            .reset  (reset),
            .load_i (adv[i]),
            .kill_i (kill[i]),
            .d_i    (d),
            .q_o    (stage_q[i])
        );
    end

    assign req_ready_out       = adv[0] && reset;
    assign busy_out            = |vld;
    assign resp_valid_out      = vld[NUM_STAGES-1];
    assign thread_id_out       = stage_q[NUM_STAGES-1].thread_id;
    assign instr_id_out        = stage_q[NUM_STAGES-1].instr_id;
    assign program_counter_out = stage_q[NUM_STAGES-1].pc;
    assign dest_reg_out        = stage_q[NUM_STAGES-1].dest_reg;
    assign data_result_out     = stage_q[NUM_STAGES-1].result;
    assign xcpt_fetch_out      = stage_q[NUM_STAGES-1].xcpt_fetch;
    assign xcpt_decode_out     = stage_q[NUM_STAGES-1].xcpt_decode;
    assign xcpt_mul_out        = stage_q[NUM_STAGES-1].xcpt_mul;

endmodule

// File: tb/tb_mul_pipeline.sv
// Directed bench for mul_pipeline: latency, overflow, backpressure,
// bubble collapse, flush and mid-flight reset.
module tb_mul_pipeline;
    import mul_pipeline_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic [THR_W-1:0]      thread_id_in;
    logic [ROB_W-1:0]      instr_id_in;
    logic [PC_W-1:0]       program_counter_in;
    logic [REG_ADDR_W-1:0] dest_reg_in;
    logic [DATA_W-1:0]     src1_data_in, src2_data_in;
    fetch_xcpt_t           xcpt_fetch_in;
    decode_xcpt_t          xcpt_decode_in;
    logic [1:0]            flush_mask_in;
    logic                  resp_valid_out;
    logic                  resp_ready_in;
    logic [THR_W-1:0]      thread_id_out;
    logic [ROB_W-1:0]      instr_id_out;
    logic [PC_W-1:0]       program_counter_out;
    logic [REG_ADDR_W-1:0] dest_reg_out;
    logic [DATA_W-1:0]     data_result_out;
    fetch_xcpt_t           xcpt_fetch_out;
    decode_xcpt_t          xcpt_decode_out;
    mul_xcpt_t             xcpt_mul_out;
    logic                  busy_out;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    mul_pipeline dut (
        .clock(clock), .reset(reset),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .thread_id_in(thread_id_in), .instr_id_in(instr_id_in),
        .program_counter_in(program_counter_in), .dest_reg_in(dest_reg_in),
        .src1_data_in(src1_data_in), .src2_data_in(src2_data_in),
        .xcpt_fetch_in(xcpt_fetch_in), .xcpt_decode_in(xcpt_decode_in),
        .flush_mask_in(flush_mask_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .thread_id_out(thread_id_out), .instr_id_out(instr_id_out),
        .program_counter_out(program_counter_out), .dest_reg_out(dest_reg_out),
        .data_result_out(data_result_out),
        .xcpt_fetch_out(xcpt_fetch_out), .xcpt_decode_out(xcpt_decode_out),
        .xcpt_mul_out(xcpt_mul_out), .busy_out(busy_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic req(input logic [THR_W-1:0] thr, input logic [ROB_W-1:0] id,
                       input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        req_valid_in       = 1'b1;
        thread_id_in       = thr;
        instr_id_in        = id;
        program_counter_in = {26'd0, id};
        dest_reg_in        = id[REG_ADDR_W-1:0];
        src1_data_in       = a;
        src2_data_in       = b;
    endtask

    int k, got, stale;
    logic [ROB_W-1:0] ids_seen [$];
    logic [ROB_W-1:0] fl_id  [5];
    logic [THR_W-1:0] fl_thr [5];

    initial begin
        reset = 1'b0; req_valid_in = 1'b0; thread_id_in = '0; instr_id_in = '0;
        program_counter_in = '0; dest_reg_in = '0; src1_data_in = '0; src2_data_in = '0;
        xcpt_fetch_in = '0; xcpt_decode_in = '0; flush_mask_in = '0; resp_ready_in = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_resp_valid", 64'(resp_valid_out), 64'd0);
        chk("rst_busy",       64'(busy_out),       64'd0);
        chk("rst_data",       64'(data_result_out), 64'd0);
        chk("rst_instr",      64'(instr_id_out),   64'd0);
        chk("rst_xcpt_mul",   64'(xcpt_mul_out),   64'd0);
        chk("rst_xcpt_dec",   64'(xcpt_decode_out), 64'd0);
        reset = 1'b1;
        tick();
        chk("rst_ready", 64'(req_ready_out), 64'd1);

        // Basic: 7 * -3, five-cycle latency
        resp_ready_in = 1'b1;
        req(1'b0, 6'd5, 32'd7, 32'hFFFF_FFFD);
        tick();
        req_valid_in = 1'b0;
        repeat (3) tick();
        chk("basic_lat4_valid", 64'(resp_valid_out), 64'd0);
        tick();
        chk("basic_valid",  64'(resp_valid_out),    64'd1);
        chk("basic_data",   64'(data_result_out),   64'hFFFF_FFEB);
        chk("basic_ovf",    64'(xcpt_mul_out),      64'd0);
        chk("basic_instr",  64'(instr_id_out),      64'd5);
        chk("basic_pc",     64'(program_counter_out), 64'd5);
        tick();
        chk("basic_drained", 64'(resp_valid_out), 64'd0);

        // Overflow, then same operands masked by a decode exception
        req(1'b0, 6'd6, 32'h4000_0000, 32'd4);
        tick();
        req(1'b0, 6'd7, 32'h4000_0000, 32'd4);
        xcpt_decode_in = '{valid: 1'b1, cause: 4'd3};
        tick();
        req_valid_in = 1'b0;
        xcpt_decode_in = '0;
        repeat (3) tick();
        chk("ovf_valid", 64'(resp_valid_out),  64'd1);
        chk("ovf_instr", 64'(instr_id_out),    64'd6);
        chk("ovf_data",  64'(data_result_out), 64'd0);
        chk("ovf_flag",  64'(xcpt_mul_out.overflow), 64'd1);
        tick();
        chk("ovfm_instr", 64'(instr_id_out),     64'd7);
        chk("ovfm_flag",  64'(xcpt_mul_out.overflow), 64'd0);
        chk("ovfm_dec",   64'(xcpt_decode_out),  64'({1'b1, 4'd3}));
        chk("ovfm_data",  64'(data_result_out),  64'd0);
        tick();

        // Backpressure: 8 requests with the output stalled
        resp_ready_in = 1'b0;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            req(1'b0, 6'(16 + k), 32'(k), 32'd3);
            #1;
            if (req_valid_in && req_ready_out) k++;
            tick();
        end
        chk("bp_accepts",    64'(k),              64'd5);
        chk("bp_full_ready", 64'(req_ready_out),  64'd0);
        chk("bp_hold_id",    64'(instr_id_out),   64'd16);
        chk("bp_hold_valid", 64'(resp_valid_out), 64'd1);
        resp_ready_in = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (k < 8) req(1'b0, 6'(16 + k), 32'(k), 32'd3);
            else       req_valid_in = 1'b0;
            #1;
            if (resp_valid_out) begin
                chk("bp_order_id",   64'(instr_id_out),    64'(16 + got));
                chk("bp_order_data", 64'(data_result_out), 64'(got * 3));
                got++;
            end
            if (req_valid_in && req_ready_out) k++;
            tick();
        end
        req_valid_in = 1'b0;
        chk("bp_count", 64'(got), 64'd8);
        repeat (2) tick();
        chk("bp_no_dup", 64'(resp_valid_out), 64'd0);

        // Bubble collapse
        resp_ready_in = 1'b0;
        req(1'b0, 6'd50, 32'd1, 32'd1);
        tick();
        req_valid_in = 1'b0;
        repeat (2) tick();
        req(1'b0, 6'd51, 32'd1, 32'd1);
        tick();
        req_valid_in = 1'b0;
        repeat (4) tick();
        chk("bub_a_id",    64'(instr_id_out),  64'd50);
        chk("bub_ready",   64'(req_ready_out), 64'd1);
        resp_ready_in = 1'b1;
        tick();
        chk("bub_b_valid", 64'(resp_valid_out), 64'd1);
        chk("bub_b_id",    64'(instr_id_out),   64'd51);
        tick();
        chk("bub_empty",   64'(busy_out),       64'd0);

        // Flush of thread 1 while thread 0 and 1 are interleaved
        fl_id  = '{6'd40, 6'd41, 6'd42, 6'd43, 6'd44};
        fl_thr = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ids_seen.delete();
        for (int c = 0; c < 20; c++) begin
            if (c < 5) req(fl_thr[c], fl_id[c], 32'd2, 32'd2);
            else       req_valid_in = 1'b0;
            flush_mask_in = (c == 4) ? 2'b10 : 2'b00;
            #1;
            if (c == 4) chk("fl_ready", 64'(req_ready_out), 64'd1);
            if (resp_valid_out) begin
                ids_seen.push_back(instr_id_out);
                chk("fl_thread", 64'(thread_id_out), 64'd0);
            end
            tick();
        end
        flush_mask_in = 2'b00;
        chk("fl_count", 64'(ids_seen.size()), 64'd3);
        if (ids_seen.size() == 3) begin
            chk("fl_id0", 64'(ids_seen[0]), 64'd40);
            chk("fl_id1", 64'(ids_seen[1]), 64'd42);
            chk("fl_id2", 64'(ids_seen[2]), 64'd44);
        end

        // Reset with three entries in flight
        for (int c = 0; c < 3; c++) begin
            req(1'b0, 6'(60 + c), 32'd3, 32'd3);
            tick();
        end
        req_valid_in = 1'b0;
        chk("rmid_busy_before", 64'(busy_out), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("rmid_resp_valid", 64'(resp_valid_out), 64'd0);
        chk("rmid_busy",       64'(busy_out),       64'd0);
        chk("rmid_ready",      64'(req_ready_out),  64'd1);
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (resp_valid_out) stale++;
            tick();
        end
        chk("rmid_stale", 64'(stale), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
